// File: rtl/dbus_sram_responder_pkg.sv
// Shared data-bus types for the responder slice.
//   dbus_req_t        : initiator -> responder request (valid, addr, size, strobe, data)
//   dbus_resp_t       : responder -> initiator response (addr_ok, data_ok, data)
//   responder_state_t : responder FSM state, also exported for observation
package dbus_sram_responder_pkg;

  typedef logic [63:0] word_t;
  typedef logic [7:0]  strobe_t;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    strobe_t     strobe;
    word_t       data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } responder_state_t;

  localparam int CNT_W = 4;

  // A request writes when any byte lane is enabled; an all-zero strobe reads.
  function automatic logic isWriteStrobe(input strobe_t s);
    return |s;
  endfunction

endpackage

// File: rtl/dbus_sram_responder_sram_1rw64.sv
// Single-port 64-bit word array with per-byte write mask and registered read.
//   clk      : clock
//   en       : access enable for this edge
//   we       : 1 = write masked bytes, 0 = read word into rdata
//   byteMask : byte-lane write enables (bit i covers wdata[8*i+7:8*i])
//   addr     : word index
//   wdata    : write data
//   rdata    : read data, valid the cycle after a read edge, held otherwise
// Contents are not initialised or cleared by any reset.
module sram_1rw64
  import dbus_sram_responder_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  strobe_t           byteMask,
  input  logic [ADDR_W-1:0] addr,
  input  word_t             wdata,
  output word_t             rdata
);

  word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 8; i++) begin
          if (byteMask[i]) begin
            mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus responder modelling a single-port word SRAM with fixed latency.
//   clk        : clock
//   reset      : synchronous, active-high
//   dreq       : request from the initiator
//   dresp      : response (addr_ok, data_ok, data)
//   busy       : high whenever the FSM is not IDLE
//   debugState : current FSM state
//
// Handshake: a request is taken at any rising edge where dreq.valid=1 and the
// FSM is IDLE; the fields are latched there and dreq is ignored until the FSM
// returns to IDLE. addr_ok pulses on the first cycle after acceptance,
// data_ok pulses exactly once, LATENCY cycles after acceptance, carrying the
// read word (or 0 for writes and out-of-range reads). The cycle after data_ok
// is always IDLE, so a held valid is taken as a fresh request one edge later.
module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter int          LATENCY     = 2,
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  dbus_req_t        dreq,
  output dbus_resp_t       dresp,
  output logic             busy,
  output responder_state_t debugState
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [63:0] SPAN     = 64'(DEPTH_WORDS) * 64'd8;
  localparam logic [63:0] LIMIT    = BASE_ADDR + SPAN;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  responder_state_t state, stateNext;
  logic [CNT_W-1:0] cnt;

  logic [63:0] reqAddr;
  strobe_t     reqStrobe;
  word_t       reqData;
  logic        reqWrite;

  logic [63:0]      offset;
  logic [IDX_W-1:0] index;
  logic             inRange;
  logic             commit;
  logic             readHit;
  word_t            rdata;

  // State and countdown. cnt is only loaded on acceptance, so it cannot wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: if (dreq.valid) cnt <= CNT_LOAD;
        WAIT: if (cnt != '0) cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Request capture; held unchanged through WAIT and RESP.
  always_ff @(posedge clk) begin
    if (!reset && state == IDLE && dreq.valid) begin
      reqAddr   <= dreq.addr;
      reqStrobe <= dreq.strobe;
      reqData   <= dreq.data;
      reqWrite  <= isWriteStrobe(dreq.strobe);
    end
  end

  // Address decode on the latched address; the low three bits select a byte
  // lane and are not part of the word index.
  assign inRange = (reqAddr >= BASE_ADDR) && (reqAddr < LIMIT);
  assign offset  = reqAddr - BASE_ADDR;
  assign index   = offset[3 +: IDX_W];

  // The array is touched only on the WAIT->RESP edge. A reset on that same
  // edge discards the request, so the write is suppressed.
  assign commit  = (state == WAIT) && (cnt == '0) && !reset;
  assign readHit = !reqWrite && inRange;

  sram_1rw64 #(
    .DEPTH  (DEPTH_WORDS),
    .ADDR_W (IDX_W)
  ) uSram (
    .clk      (clk),
    .en       (commit && inRange),
    .we       (reqWrite),
    .byteMask (reqStrobe),
    .addr     (index),
    .wdata    (reqData),
    .rdata    (rdata)
  );

  always_comb begin
    stateNext = state;
    dresp     = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (dreq.valid) stateNext = WAIT;
      end
      WAIT: begin
        // cnt equals its load value only on the first WAIT cycle.
        dresp.addr_ok = (cnt == CNT_LOAD);
        if (cnt == '0) stateNext = RESP;
      end
      RESP: begin
        dresp.data_ok = 1'b1;
        dresp.data    = readHit ? rdata : '0;
        stateNext     = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign debugState = state;

  // Bits that are deliberately not consumed.
  logic unusedBits;
  assign unusedBits = ^{dreq.size, offset[63:3+IDX_W], offset[2:0]};

endmodule

// File: tb/tb_dbus_sram_responder.sv
module tb_dbus_sram_responder;
  import dbus_sram_responder_pkg::*;

  localparam int          LAT   = 2;
  localparam int          DEPTH = 4096;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dbus_req_t        dreq, dreq1;
  dbus_resp_t       dresp, dresp1;
  logic             busy, busy1;
  responder_state_t st, st1;

  dbus_sram_responder #(.LATENCY(LAT), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .dreq(dreq), .dresp(dresp), .busy(busy), .debugState(st)
  );

  dbus_sram_responder #(.LATENCY(1), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut1 (
    .clk(clk), .reset(reset), .dreq(dreq1), .dresp(dresp1), .busy(busy1), .debugState(st1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transaction view: a request accepted at edge accE answers addr_ok in the
  // cycle after accE, takes effect at edge accE+LAT, answers data_ok in the
  // cycle after that, and frees the responder at edge accE+LAT+1.
  longint unsigned edgeN   = 0;
  longint unsigned accE    = 0;
  bit              mActive = 1'b0;
  bit              started = 1'b0;
  logic [63:0]     mAddr;
  strobe_t         mStrb;
  word_t           mData;
  word_t           mExpData;
  word_t           mem [int];
  int              mIdx;
  word_t           mWord;

  function automatic bit inRng(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(DEPTH) * 64'd8);
  endfunction

  always @(posedge clk) begin
    edgeN++;
    if (reset) begin
      mActive = 1'b0;
      started = 1'b1;
    end else if (mActive) begin
      if (edgeN == accE + LAT) begin
        mExpData = '0;
        if (inRng(mAddr)) begin
          mIdx = int'((mAddr - BASE) >> 3);
          if (mStrb != 8'h00) begin
            mWord = mem.exists(mIdx) ? mem[mIdx] : '0;
            for (int b = 0; b < 8; b++)
              if (mStrb[b]) mWord[b*8 +: 8] = mData[b*8 +: 8];
            mem[mIdx] = mWord;
          end else begin
            mExpData = mem.exists(mIdx) ? mem[mIdx] : 'x;
          end
        end
      end
      if (edgeN == accE + LAT + 1) mActive = 1'b0;
    end else if (dreq.valid === 1'b1) begin
      mActive = 1'b1;
      accE    = edgeN;
      mAddr   = dreq.addr;
      mStrb   = dreq.strobe;
      mData   = dreq.data;
    end
  end

  // ---------------- scoreboard / compare ----------------
  bit expAddrOk, expDataOk;
  always @(negedge clk) begin
    if (started) begin
      expAddrOk = mActive && (edgeN == accE);
      expDataOk = mActive && (edgeN == accE + LAT);
      chk("busy", busy, mActive);
      chk("addr_ok", dresp.addr_ok, expAddrOk);
      chk("data_ok", dresp.data_ok, expDataOk);
      if (expDataOk) chk("resp_data", dresp.data, mExpData);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic scramble();
    dreq.addr   = {32'hDEAD_BEEF, $urandom};
    dreq.strobe = 8'($urandom);
    dreq.data   = {$urandom, $urandom};
  endtask

  // Issue one request starting at the current negedge; returns at the negedge
  // of the data_ok cycle. With hold=1 valid stays high for the next request.
  task automatic doReq(input logic [63:0] a, input strobe_t s, input word_t d,
                       input bit hold, output word_t rd);
    bit got;
    got = 1'b0;
    rd  = '0;
    dreq.valid  = 1'b1;
    dreq.addr   = a;
    dreq.strobe = s;
    dreq.data   = d;
    dreq.size   = MSIZE8;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (dresp.addr_ok) begin
        dreq.valid = hold;
        scramble();
      end
      if (dresp.data_ok) begin
        rd  = dresp.data;
        got = 1'b1;
      end
    end
    if (!got) chk("req_timeout", 64'(got), 64'd1);
    if (!hold) dreq.valid = 1'b0;
  endtask

  // Accept a request, then reset 'delay' cycles into it.
  task automatic resetMid(input logic [63:0] a, input strobe_t s, input word_t d, input int delay);
    bit seen;
    seen = 1'b0;
    dreq.valid  = 1'b1;
    dreq.addr   = a;
    dreq.strobe = s;
    dreq.data   = d;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (dresp.addr_ok) seen = 1'b1;
    end
    if (!seen) chk("rst_mid_timeout", 64'(seen), 64'd1);
    dreq.valid = 1'b0;
    repeat (delay) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [63:0] randAddr();
    if ($urandom_range(0, 9) == 0) begin
      if ($urandom_range(0, 1) == 0) return BASE - 64'(8 * $urandom_range(1, 100));
      return BASE + 64'(DEPTH) * 64'd8 + 64'($urandom_range(0, 1000));
    end
    return BASE + 64'($urandom_range(0, 15)) * 64'd8 + 64'($urandom_range(0, 7));
  endfunction

  function automatic strobe_t randStrobe();
    int k;
    k = $urandom_range(0, 2);
    if (k == 0) return 8'h00;
    if (k == 1) return 8'hFF;
    return 8'($urandom);
  endfunction

  // ---------------- stimulus ----------------
  word_t rd;
  int    dokCount;
  bit    prevHold;

  initial begin
    dreq  = '0;
    dreq1 = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_addr_ok", dresp.addr_ok, 1'b0);
    chk("rst_data_ok", dresp.data_ok, 1'b0);
    chk("rst_data", dresp.data, 64'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", st, IDLE);
    reset = 1'b0;

    // Write with explicit cycle-level timing.
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h8000_0010;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'h1122_3344_5566_7788;
    @(negedge clk);
    chk("t_addr_ok_c1", dresp.addr_ok, 1'b1);
    chk("t_busy_c1", busy, 1'b1);
    dreq.valid = 1'b0;
    @(negedge clk);
    chk("t_addr_ok_c2", dresp.addr_ok, 1'b0);
    chk("t_data_ok_c2", dresp.data_ok, 1'b0);
    @(negedge clk);
    chk("t_data_ok_c3", dresp.data_ok, 1'b1);
    chk("t_wdata_c3", dresp.data, 64'h0);
    @(negedge clk);
    chk("t_data_ok_c4", dresp.data_ok, 1'b0);
    chk("t_busy_c4", busy, 1'b0);

    doReq(64'h8000_0010, 8'h00, '0, 1'b0, rd);
    chk("read_full", rd, 64'h1122_3344_5566_7788);

    doReq(64'h8000_0010, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 1'b0, rd);
    doReq(64'h8000_0017, 8'h00, '0, 1'b0, rd);
    chk("read_strobed", rd, 64'h1122_3344_BBBB_BBBB);

    for (int i = 0; i < 16; i++)
      if (i != 2) doReq(BASE + 64'(i) * 64'd8, 8'hFF, 64'hC0DE_0000_0000_0000 | 64'(i), 1'b0, rd);

    // Back-to-back with valid held.
    doReq(64'h8000_0020, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b1, rd);
    doReq(64'h8000_0020, 8'h00, '0, 1'b0, rd);
    chk("b2b_read", rd, 64'h0123_4567_89AB_CDEF);
    dokCount = 0;
    repeat (6) begin
      @(negedge clk);
      if (dresp.data_ok) dokCount++;
    end
    chk("b2b_no_extra", 64'(dokCount), 64'd0);

    // Out of range.
    doReq(64'h7FFF_FFF8, 8'h00, '0, 1'b0, rd);
    chk("oor_read", rd, 64'h0);
    doReq(64'h8000_8000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, rd);
    doReq(64'h8000_0000, 8'h00, '0, 1'b0, rd);
    chk("oor_write_dropped", rd, 64'hC0DE_0000_0000_0000);

    // Reset during WAIT.
    @(negedge clk);
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h8000_0040;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'h5555_5555_5555_5555;
    @(negedge clk);
    chk("rw_addr_ok", dresp.addr_ok, 1'b1);
    dreq.valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rw_busy", busy, 1'b0);
    dokCount = 0;
    repeat (4) begin
      if (dresp.data_ok) dokCount++;
      @(negedge clk);
    end
    chk("rw_no_data_ok", 64'(dokCount), 64'd0);
    doReq(64'h8000_0040, 8'h00, '0, 1'b0, rd);
    chk("rw_unchanged", rd, 64'hC0DE_0000_0000_0008);

    // Randomised traffic, checked by the model.
    prevHold = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bit hold;
      hold = ($urandom_range(0, 3) == 0) && (i < 299);
      if (!prevHold && $urandom_range(0, 99) < 6) begin
        resetMid(randAddr(), randStrobe(), {$urandom, $urandom}, $urandom_range(0, LAT));
        hold = 1'b0;
      end else begin
        doReq(randAddr(), randStrobe(), {$urandom, $urandom}, hold, rd);
      end
      prevHold = hold;
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    dreq.valid = 1'b0;
    repeat (6) @(negedge clk);

    // LATENCY=1 instance.
    dreq1.valid  = 1'b1;
    dreq1.addr   = 64'h8000_0018;
    dreq1.strobe = 8'hFF;
    dreq1.data   = 64'hFEED_FACE_CAFE_BABE;
    @(negedge clk);
    chk("l1_addr_ok", dresp1.addr_ok, 1'b1);
    chk("l1_busy", busy1, 1'b1);
    chk("l1_data_ok_early", dresp1.data_ok, 1'b0);
    dreq1.valid = 1'b0;
    @(negedge clk);
    chk("l1_data_ok", dresp1.data_ok, 1'b1);
    chk("l1_addr_ok_low", dresp1.addr_ok, 1'b0);
    @(negedge clk);
    chk("l1_idle", busy1, 1'b0);
    dreq1.valid  = 1'b1;
    dreq1.strobe = 8'h00;
    @(negedge clk);
    chk("l1_rd_addr_ok", dresp1.addr_ok, 1'b1);
    dreq1.valid = 1'b0;
    @(negedge clk);
    chk("l1_rd_data_ok", dresp1.data_ok, 1'b1);
    chk("l1_rd_data", dresp1.data, 64'hFEED_FACE_CAFE_BABE);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule
